// File: rtl/input_conditioner_pkg.sv
// Shared constants and types for the switch/start input conditioner.
// Board defaults target a 50 MHz clock with a 1 ms debounce window.
package input_conditioner_pkg;

  localparam int unsigned CLK_HZ                = 50_000_000;
  localparam int unsigned DEBOUNCE_MS           = 1;
  localparam int unsigned DEBOUNCE_CYCLES_BOARD = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int unsigned DEBOUNCE_CYCLES_SIM   = 4;
  localparam int unsigned WIDTH_DEFAULT         = 10;
  localparam int unsigned CNT_W_DEFAULT         = 16;

  typedef enum logic {
    CH_STABLE,
    CH_PENDING
  } chan_state_e;

  // The start key sits just above the slide switches in the channel vector.
  function automatic int unsigned start_channel(input int unsigned width);
    return width;
  endfunction

endpackage

// File: rtl/input_conditioner_channel.sv
// One conditioned input: 2-FF synchroniser, debounce counter and
// registered rise/fall flags aligned with the accepted level.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_BOARD,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rose,
  output logic fell
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             stable_nxt;
  logic             rose_nxt;
  logic             fell_nxt;
  chan_state_e      state;

  // State is implied by sync2 vs. stable; a disagreement that ends early
  // drops back to CH_STABLE, which zeroes the partial count.
  always_comb begin
    state      = (sync2 != stable) ? CH_PENDING : CH_STABLE;
    cnt_nxt    = '0;
    stable_nxt = stable;
    rose_nxt   = 1'b0;
    fell_nxt   = 1'b0;
    case (state)
      CH_STABLE: cnt_nxt = '0;
      CH_PENDING: begin
        if (cnt == CNT_TERM) begin
          stable_nxt = sync2;
          rose_nxt   = sync2;
          fell_nxt   = ~sync2;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: cnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      rose   <= 1'b0;
      fell   <= 1'b0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      cnt    <= cnt_nxt;
      stable <= stable_nxt;
      rose   <= rose_nxt;
      fell   <= fell_nxt;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Conditions the board slide switches and start key for the game status FSM:
// synchronised, debounced levels plus change/press pulses.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned WIDTH            = WIDTH_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_BOARD,
  parameter int unsigned CNT_W            = CNT_W_DEFAULT,
  parameter bit          START_ACTIVE_LOW = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] switch_raw,
  input  logic             start_raw,
  output logic [WIDTH-1:0] switch_stable,
  output logic             switch_changed,
  output logic             start_level,
  output logic             start_pulse
);

  localparam int unsigned START_CH = start_channel(WIDTH);

  logic [WIDTH:0] chan_raw;
  logic [WIDTH:0] chan_stable;
  logic [WIDTH:0] chan_rose;
  logic [WIDTH:0] chan_fell;
  logic           start_fell_unused;

  // Normalising before the synchroniser makes an idle low-active key read 0.
  assign chan_raw = {(START_ACTIVE_LOW ? ~start_raw : start_raw), switch_raw};

  for (genvar i = 0; i < WIDTH + 1; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_chan (
      .clock (clock),
      .reset (reset),
      .raw   (chan_raw[i]),
      .stable(chan_stable[i]),
      .rose  (chan_rose[i]),
      .fell  (chan_fell[i])
    );
  end

  // Outputs are driven straight from channel flops, so they land on the
  // same edge as the accepted level with no input-to-output path.
  assign switch_stable     = chan_stable[WIDTH-1:0];
  assign switch_changed    = |(chan_rose[WIDTH-1:0] | chan_fell[WIDTH-1:0]);
  assign start_level       = chan_stable[START_CH];
  assign start_pulse       = chan_rose[START_CH];
  assign start_fell_unused = chan_fell[START_CH];

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: window-based reference model checked every
// cycle, plus directed scenarios with hand-computed edge timings.
module tb_input_conditioner;
  import input_conditioner_pkg::*;

  localparam int W = 10;
  localparam int D = int'(DEBOUNCE_CYCLES_SIM);

  logic         clock;
  logic         reset;
  logic [W-1:0] switch_raw;
  logic         start_raw;
  logic [W-1:0] switch_stable;
  logic         switch_changed;
  logic         start_level;
  logic         start_pulse;

  int checks    = 0;
  int failures  = 0;
  int chg_cnt   = 0;
  int pulse_cnt = 0;

  input_conditioner #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_SIM),
    .CNT_W           (16),
    .START_ACTIVE_LOW(1'b1)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .switch_raw    (switch_raw),
    .start_raw     (start_raw),
    .switch_stable (switch_stable),
    .switch_changed(switch_changed),
    .start_level   (start_level),
    .start_pulse   (start_pulse)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: a channel accepts a new level once the synchronised
  // samples seen over the last D edges all disagree with its current level.
  logic [W:0] q_raw[$];
  logic [W:0] s2_hist[$];
  logic [W:0] m_stable  = '0;
  logic       m_changed = 1'b0;
  logic       m_pulse   = 1'b0;
  logic [W:0] m_s2;
  logic [W:0] m_nxt;
  bit         m_all;

  initial begin
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        q_raw.delete();
        q_raw.push_back('0);
        q_raw.push_back('0);
        s2_hist.delete();
        m_stable  = '0;
        m_changed = 1'b0;
        m_pulse   = 1'b0;
      end else begin
        m_s2 = q_raw.pop_front();
        q_raw.push_back({~start_raw, switch_raw});
        s2_hist.push_back(m_s2);
        if (s2_hist.size() > D) void'(s2_hist.pop_front());
        m_nxt = m_stable;
        if (s2_hist.size() == D) begin
          for (int c = 0; c <= W; c++) begin
            m_all = 1'b1;
            foreach (s2_hist[k]) if (s2_hist[k][c] == m_stable[c]) m_all = 1'b0;
            if (m_all) m_nxt[c] = ~m_stable[c];
          end
        end
        m_changed = |(m_nxt[W-1:0] ^ m_stable[W-1:0]);
        m_pulse   = m_nxt[W] & ~m_stable[W];
        m_stable  = m_nxt;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      chk("cmp_switch_stable", 32'(switch_stable), 32'(m_stable[W-1:0]));
      chk("cmp_switch_changed", 32'(switch_changed), 32'(m_changed));
      chk("cmp_start_level", 32'(start_level), 32'(m_stable[W]));
      chk("cmp_start_pulse", 32'(start_pulse), 32'(m_pulse));
    end
  end

  // Advance one edge and tally the pulse outputs seen after it.
  task automatic step();
    @(posedge clock);
    #1;
    if (switch_changed) chg_cnt++;
    if (start_pulse) pulse_cnt++;
  endtask

  int c;

  initial begin
    // 1: reset with switches high and start key pressed (low-active)
    reset      = 1'b0;
    switch_raw = '1;
    start_raw  = 1'b0;
    repeat (3) step();
    chk("rst_switch_stable", 32'(switch_stable), 32'h0);
    chk("rst_switch_changed", 32'(switch_changed), 32'h0);
    chk("rst_start_level", 32'(start_level), 32'h0);
    chk("rst_start_pulse", 32'(start_pulse), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    repeat (5) step();
    chk("t1_edge4_stable", 32'(switch_stable), 32'h0);
    step();
    chk("t1_edge5_stable", 32'(switch_stable), 32'h3FF);
    chk("t1_edge5_changed", 32'(switch_changed), 32'h1);
    chk("t1_edge5_level", 32'(start_level), 32'h1);
    chk("t1_edge5_pulse", 32'(start_pulse), 32'h1);
    step();
    chk("t1_edge6_changed", 32'(switch_changed), 32'h0);
    chk("t1_edge6_pulse", 32'(start_pulse), 32'h0);

    @(negedge clock);
    switch_raw = '0;
    start_raw  = 1'b1;
    repeat (12) step();

    // 2: latency of a single-bit change
    @(negedge clock);
    chg_cnt    = 0;
    switch_raw = 10'h200;
    repeat (5) step();
    chk("t2_edge4_stable", 32'(switch_stable), 32'h0);
    chk("t2_edge4_count", 32'(chg_cnt), 32'h0);
    step();
    chk("t2_edge5_stable", 32'(switch_stable), 32'h200);
    chk("t2_edge5_changed", 32'(switch_changed), 32'h1);
    chk("t2_model_pin", 32'(m_stable), 32'h200);
    step();
    chk("t2_pulse_count", 32'(chg_cnt), 32'h1);

    // 3: bounce on bit 0, each level held only 2 cycles
    chg_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      switch_raw[0] = (i % 2 == 0);
      repeat (2) step();
    end
    @(negedge clock);
    switch_raw[0] = 1'b1;
    repeat (5) step();
    chk("t3_edge4_stable", 32'(switch_stable), 32'h200);
    step();
    chk("t3_edge5_stable", 32'(switch_stable), 32'h201);
    step();
    chk("t3_pulse_count", 32'(chg_cnt), 32'h1);

    // 4: start press held 20 cycles, then released
    pulse_cnt = 0;
    @(negedge clock);
    start_raw = 1'b0;
    repeat (5) step();
    chk("t4_edge4_level", 32'(start_level), 32'h0);
    step();
    chk("t4_edge5_level", 32'(start_level), 32'h1);
    chk("t4_edge5_pulse", 32'(start_pulse), 32'h1);
    step();
    chk("t4_edge6_pulse", 32'(start_pulse), 32'h0);
    repeat (13) step();
    @(negedge clock);
    start_raw = 1'b1;
    repeat (10) step();
    chk("t4_release_level", 32'(start_level), 32'h0);
    chk("t4_pulse_count", 32'(pulse_cnt), 32'h1);

    // 5: bits 3 and 7 change together
    chg_cnt = 0;
    @(negedge clock);
    switch_raw = 10'h289;
    repeat (5) step();
    chk("t5_edge4_stable", 32'(switch_stable), 32'h201);
    step();
    chk("t5_edge5_stable", 32'(switch_stable), 32'h289);
    chk("t5_edge5_changed", 32'(switch_changed), 32'h1);
    step();
    chk("t5_pulse_count", 32'(chg_cnt), 32'h1);

    // 6: reset in the middle of a pending 0->1 on bit 1
    @(negedge clock);
    switch_raw = 10'h28B;
    repeat (4) step();
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("t6_in_reset_stable", 32'(switch_stable), 32'h0);
    repeat (2) step();
    @(negedge clock);
    reset   = 1'b1;
    chg_cnt = 0;
    repeat (5) step();
    chk("t6_edge4_stable", 32'(switch_stable), 32'h0);
    step();
    chk("t6_edge5_stable", 32'(switch_stable), 32'h28B);
    chk("t6_model_pin", 32'(m_stable), 32'h28B);
    step();
    chk("t6_pulse_count", 32'(chg_cnt), 32'h1);

    // Random phase: sparse flips give a mix of accepted changes and glitches.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      if (n == 1500) reset = 1'b0;
      if (n == 1504) reset = 1'b1;
      if ($urandom_range(0, 2) == 0) begin
        c = int'($urandom_range(0, W));
        if (c == W) start_raw = ~start_raw;
        else switch_raw[c] = ~switch_raw[c];
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
